// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit for the E stage: owns HI/LO, computes the result at the
// start edge and commits it after a configurable busy window so the stall unit can hold D.
module e_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] MDUOut
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ZERO  = {WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   pend_hi_q;
    logic [WIDTH-1:0]   pend_lo_q;
    logic               pend_skip_q;

    logic               launch;
    logic [WIDTH-1:0]   pend_hi_d;
    logic [WIDTH-1:0]   pend_lo_d;
    logic               pend_skip_d;
    logic [CNT_W-1:0]   cnt_load_d;

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   div_b;
    logic [WIDTH-1:0]   uq;
    logic [WIDTH-1:0]   ur;
    logic [WIDTH-1:0]   sq;
    logic [WIDTH-1:0]   sr;

    assign launch = start && (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU);

    // Arithmetic on the operands as presented; the result is latched only on a launch edge.
    always_comb begin
        sign_a = A[WIDTH-1];
        sign_b = B[WIDTH-1];
        prod_s = {{WIDTH{sign_a}}, A} * {{WIDTH{sign_b}}, B};
        prod_u = {W_ZERO, A} * {W_ZERO, B};
        // Signed divide runs on magnitudes so MIN / -1 cannot overflow.
        mag_a  = sign_a ? (W_ZERO - A) : A;
        mag_b  = sign_b ? (W_ZERO - B) : B;
        if (B == W_ZERO) begin
            mag_b = W_ONE;
            div_b = W_ONE;
        end else begin
            div_b = B;
        end
        uq = mag_a / mag_b;
        ur = mag_a % mag_b;
        sq = (sign_a ^ sign_b) ? (W_ZERO - uq) : uq;
        sr = sign_a ? (W_ZERO - ur) : ur;
    end

    // Selects the pending result and busy length for the operation being launched.
    always_comb begin
        pend_hi_d   = W_ZERO;
        pend_lo_d   = W_ZERO;
        pend_skip_d = 1'b0;
        cnt_load_d  = MULT_N;
        case (MDUOp)
            OP_MULT: begin
                pend_hi_d = prod_s[2*WIDTH-1:WIDTH];
                pend_lo_d = prod_s[WIDTH-1:0];
            end
            OP_MULTU: begin
                pend_hi_d = prod_u[2*WIDTH-1:WIDTH];
                pend_lo_d = prod_u[WIDTH-1:0];
            end
            OP_DIV: begin
                pend_hi_d   = sr;
                pend_lo_d   = sq;
                pend_skip_d = (B == W_ZERO);
                cnt_load_d  = DIV_N;
            end
            OP_DIVU: begin
                pend_hi_d   = A % div_b;
                pend_lo_d   = A / div_b;
                pend_skip_d = (B == W_ZERO);
                cnt_load_d  = DIV_N;
            end
            default: begin
                pend_hi_d   = W_ZERO;
                pend_lo_d   = W_ZERO;
                pend_skip_d = 1'b0;
                cnt_load_d  = MULT_N;
            end
        endcase
    end

    // Sequencing FSM: launch, count down the busy window, commit HI/LO on the final edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            busy_q      <= 1'b0;
            hi_q        <= W_ZERO;
            lo_q        <= W_ZERO;
            pend_hi_q   <= W_ZERO;
            pend_lo_q   <= W_ZERO;
            pend_skip_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        state_q     <= ST_RUN;
                        cnt_q       <= cnt_load_d;
                        busy_q      <= 1'b1;
                        pend_hi_q   <= pend_hi_d;
                        pend_lo_q   <= pend_lo_d;
                        pend_skip_q <= pend_skip_d;
                    end else if (MDUOp == OP_MTHI) begin
                        hi_q <= A;
                    end else if (MDUOp == OP_MTLO) begin
                        lo_q <= A;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == CNT_ONE) begin
                        if (!pend_skip_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        // A start on the committing edge is taken immediately.
                        if (launch) begin
                            cnt_q       <= cnt_load_d;
                            busy_q      <= 1'b1;
                            pend_hi_q   <= pend_hi_d;
                            pend_lo_q   <= pend_lo_d;
                            pend_skip_q <= pend_skip_d;
                        end else begin
                            state_q <= ST_IDLE;
                            cnt_q   <= {CNT_W{1'b0}};
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= {CNT_W{1'b0}};
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Move-from read path is a plain mux on the architectural registers.
    always_comb begin
        case (MDUOp)
            OP_MFHI: MDUOut = hi_q;
            OP_MFLO: MDUOut = lo_q;
            default: MDUOut = W_ZERO;
        endcase
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
